mmio_uart_tx: RTL
=================

// Module: mmio_uart_tx
// PURPOSE
//   Memory-mapped UART transmitter acting as a responder on the CPU data-memory bus (cpu_mem_* signals).
//   The CPU pushes bytes by storing to TXDATA. A FIFO buffers them, and an 8N1 serializer drives the tx pin.
//   Sits beside the data memory; top level selects cpu_mem_rd_data from this block when mmio_hit=1.
// PARAMETERS
//   BASE_ADDR   32'h0000_1000  byte address of register window (16-byte aligned)
//   FIFO_DEPTH  8              TX FIFO entries, power of 2, 2..64
//   DIV_WIDTH   16             width of baud divisor register
//   DIV_RESET   16'd4          divisor value after reset (clocks per bit)
// PORTS
//   clk              in   1   CPU clock, all state on rising edge
//   rst              in   1   synchronous reset, active-high
//   cpu_mem_addr     in   32  byte address from CPU
//   cpu_mem_wr_ena   in   1   store strobe, sampled at rising edge
//   cpu_mem_wr_data  in   32  store data
//   cpu_mem_rd_data  out  32  combinational read data
//   mmio_hit         out  1   combinational: addr[31:4]==BASE_ADDR[31:4]
//   tx               out  1   serial output, registered, idle high
// BEHAVIOUR
//   Register map (decode on addr[3:2]; addr[1:0] ignored):
//     +0x0 TXDATA  W: push wr_data[7:0] to FIFO. R: 0.
//     +0x4 STATUS  R: {24'b0, count[7:4], ovf, busy, empty, full}. W (any value): clears ovf.
//     +0x8 DIVISOR R/W: [DIV_WIDTH-1:0]; upper bits read 0, writes ignore them.
//     +0xC reserved: reads 0, writes ignored.
//   Out-of-window: rd_data=0, mmio_hit=0, writes have no effect.
//   Reads are combinational from current registered state, same cycle as addr (single-cycle CPU).
//   Reset: tx=1, FIFO empty (count=0), ovf=0, DIVISOR=DIV_RESET, FSM=IDLE, bit counter=0.
//     Reset mid-frame aborts the frame; tx is 1 after the reset edge.
//   FIFO:
//     - Push accepted iff full=0 at that edge. A pop in the same cycle does not free a slot for the push.
//     - A rejected push sets ovf (sticky). A push while empty may coincide with no pop; the FIFO is never bypassed.
//     - count saturates at FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
//   FSM (states IDLE, START, DATA, STOP), each bit held for D clocks:
//     - D = DIVISOR, with D=0 treated as 1.
//     - IDLE: if !empty -> pop head, load shift reg, tx<=0, go START.
//     - START: after D clocks -> tx<=bit0, go DATA.
//     - DATA: after D clocks per bit, LSB first, 8 bits; after bit7 -> tx<=1, go STOP.
//     - STOP: after D clocks -> if !empty pop and go START back-to-back (tx<=0), else IDLE.
//   busy = (FSM != IDLE).
//   Latency: store at edge N (FIFO empty, IDLE) -> pop and tx=0 after edge N+1. Frame length is 10*D clocks.
//   DIVISOR write mid-frame: current bit keeps its old count; the new value applies from the next bit boundary.
//   Simultaneous push + pop: both happen; count unchanged.
// TESTING
//   1. rst=1 for 3 clocks -> tx=1, STATUS=0x0000_0002, DIVISOR reads 0x0000_0004.
//   2. D=4, store 0x55 to 0x1000 -> tx low after edge N+1.
//      Then 0,1,0,1,0,1,0,1,0 then stop 1, each 4 clocks (40 clocks total). busy=1 throughout, then 0.
//   3. Store 0x41,0x42,0x43 back-to-back -> three frames with no idle gap. STATUS count 2 then 1 then 0 as bytes pop.
//   4. D=1000, store 9 bytes -> first pops, remaining 8 fill FIFO (full=1, ovf=0).
//      10th store -> ovf=1, byte dropped. Store to STATUS -> ovf=0.
//   5. Store to 0x2000 and read 0x2000 -> mmio_hit=0, rd_data=0, FIFO/DIVISOR unchanged.
//      Write DIVISOR=0 -> 1-clock bits.
//   6. Assert rst mid-DATA of 0xA5 with 3 bytes queued -> tx=1, empty=1, busy=0 after the edge.
//      No further frames are sent.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter that responds on the CPU data-memory bus.
//   The CPU stores bytes to TXDATA. They queue in a small FIFO, and a serializer
//   shifts each byte out on tx, LSB first. Every bit lasts DIVISOR clocks, and a
//   DIVISOR of 0 is treated as 1.
//
//   Register window (BASE_ADDR, 16 bytes, decoded on addr[3:2]):
//     +0x0 TXDATA  W: push wr_data[7:0]          R: 0
//     +0x4 STATUS  R: {24'b0, count, ovf, busy, empty, full}   W: clear ovf
//     +0x8 DIVISOR R/W: clocks per bit, DIV_WIDTH bits
//     +0xC reserved: reads 0, writes ignored
//
// Ports
//   clk              rising-edge clock for all state
//   rst              synchronous reset, active high
//   cpu_mem_addr     byte address from the CPU
//   cpu_mem_wr_ena   store strobe
//   cpu_mem_wr_data  store data
//   cpu_mem_rd_data  combinational read data, 0 outside the window
//   mmio_hit         combinational: address falls in the register window
//   tx               registered serial output, idle high
module mmio_uart_tx #(
  parameter logic [31:0]          BASE_ADDR  = 32'h0000_1000,
  parameter int                   FIFO_DEPTH = 8,
  parameter int                   DIV_WIDTH  = 16,
  parameter logic [DIV_WIDTH-1:0] DIV_RESET  = 16'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_mem_addr,
  input  logic        cpu_mem_wr_ena,
  input  logic [31:0] cpu_mem_wr_data,
  output logic [31:0] cpu_mem_rd_data,
  output logic        mmio_hit,
  output logic        tx
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [7:0]           fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic                 ovf_r;
  logic [DIV_WIDTH-1:0] div_r;
  logic [DIV_WIDTH-1:0] bit_div_r;   // bit length latched at each bit boundary
  logic [DIV_WIDTH-1:0] clk_cnt_r;   // clocks elapsed in the current bit
  state_t               state_r;
  logic [7:0]           shift_r;
  logic [2:0]           bit_idx_r;

  logic                 full_s;
  logic                 empty_s;
  logic                 busy_s;
  logic                 wr_txdata_s;
  logic                 wr_status_s;
  logic                 wr_div_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 bit_end_s;
  logic [DIV_WIDTH-1:0] eff_div_s;
  logic [7:0]           head_s;
  logic                 unused_s;

  // The count field is 4 bits wide; deeper FIFOs report 15 once they hold more than 15.
  function automatic logic [3:0] count_field(input logic [CW-1:0] c);
    logic [7:0] c8;
    c8 = 8'(c);
    if (c8 > 8'd15) begin
      count_field = 4'hF;
    end else begin
      count_field = c8[3:0];
    end
  endfunction

  assign unused_s = &{1'b0, cpu_mem_addr[1:0], cpu_mem_wr_data};

  // FIFO flags, pop decision and bit timing.
  always_comb begin
    full_s    = (count_r == CW'(FIFO_DEPTH));
    empty_s   = (count_r == CW'(0));
    busy_s    = (state_r != IDLE);
    eff_div_s = (div_r == DIV_WIDTH'(0)) ? DIV_WIDTH'(1) : div_r;
    bit_end_s = (clk_cnt_r == bit_div_r - DIV_WIDTH'(1));
    head_s    = fifo_mem_r[rd_ptr_r];
    push_s    = wr_txdata_s && !full_s;
    pop_s     = !empty_s && ((state_r == IDLE) || ((state_r == STOP) && bit_end_s));
  end

  // Address decode, write strobes and combinational read mux.
  always_comb begin
    mmio_hit        = (cpu_mem_addr[31:4] == BASE_ADDR[31:4]);
    wr_txdata_s     = 1'b0;
    wr_status_s     = 1'b0;
    wr_div_s        = 1'b0;
    cpu_mem_rd_data = 32'd0;
    if (mmio_hit) begin
      case (cpu_mem_addr[3:2])
        2'd0: wr_txdata_s = cpu_mem_wr_ena;
        2'd1: begin
          wr_status_s     = cpu_mem_wr_ena;
          cpu_mem_rd_data = {24'd0, count_field(count_r), ovf_r, busy_s, empty_s, full_s};
        end
        2'd2: begin
          wr_div_s        = cpu_mem_wr_ena;
          cpu_mem_rd_data = 32'(div_r);
        end
        default: cpu_mem_rd_data = 32'd0;
      endcase
    end else begin
      cpu_mem_rd_data = 32'd0;
    end
  end

  // FIFO storage; the contents need no reset because count_r gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= cpu_mem_wr_data[7:0];
    end
  end

  // FIFO pointers, occupancy, overflow flag and divisor register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
      ovf_r    <= 1'b0;
      div_r    <= DIV_RESET;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      // A rejected push and an ovf clear cannot coincide; they use different addresses.
      if (wr_txdata_s && full_s) begin
        ovf_r <= 1'b1;
      end else if (wr_status_s) begin
        ovf_r <= 1'b0;
      end
      if (wr_div_s) begin
        div_r <= cpu_mem_wr_data[DIV_WIDTH-1:0];
      end
    end
  end

  // Serializer FSM. The divisor is sampled only at bit boundaries, so a bit in flight keeps its length.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      tx        <= 1'b1;
      shift_r   <= 8'd0;
      bit_idx_r <= 3'd0;
      clk_cnt_r <= DIV_WIDTH'(0);
      bit_div_r <= DIV_WIDTH'(1);
    end else begin
      case (state_r)
        IDLE: begin
          if (!empty_s) begin
            shift_r   <= head_s;
            tx        <= 1'b0;
            clk_cnt_r <= DIV_WIDTH'(0);
            bit_div_r <= eff_div_s;
            state_r   <= START;
          end
        end
        START: begin
          if (bit_end_s) begin
            tx        <= shift_r[0];
            clk_cnt_r <= DIV_WIDTH'(0);
            bit_div_r <= eff_div_s;
            bit_idx_r <= 3'd0;
            state_r   <= DATA;
          end else begin
            clk_cnt_r <= clk_cnt_r + DIV_WIDTH'(1);
          end
        end
        DATA: begin
          if (bit_end_s) begin
            clk_cnt_r <= DIV_WIDTH'(0);
            bit_div_r <= eff_div_s;
            if (bit_idx_r == 3'd7) begin
              tx        <= 1'b1;
              bit_idx_r <= 3'd0;
              state_r   <= STOP;
            end else begin
              // shift_r[0] is the bit on the wire, so shift_r[1] comes next.
              tx        <= shift_r[1];
              shift_r   <= shift_r >> 1;
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + DIV_WIDTH'(1);
          end
        end
        STOP: begin
          if (bit_end_s) begin
            clk_cnt_r <= DIV_WIDTH'(0);
            bit_div_r <= eff_div_s;
            if (!empty_s) begin
              shift_r <= head_s;
              tx      <= 1'b0;
              state_r <= START;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + DIV_WIDTH'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          tx      <= 1'b1;
        end
      endcase
    end
  end

endmodule
